neuron_mul_unit: RTL and testbench



---
 rtl/neuron_mul_unit.sv | 153 +++++++++++++++
 tb/tb_neuron_mul_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mul_unit.sv
// Bit-serial signed fixed-point multiplier answering the neuron enable/done/unit_rst handshake.
// Build option: define MUL_SAT_EN to clamp the scaled product instead of wrapping it.
module neuron_mul_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             unit_rst,
    input  logic             enable,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             sel_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_sign;
    logic [WIDTH-1:0]  r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_sel_err;

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic [WIDTH-1:0]  w_fmt;

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (sel)
            2'd1:    begin w_a = x1; w_b = w1; end
            2'd2:    begin w_a = x2; w_b = w2; end
            2'd3:    begin w_a = x3; w_b = w3; end
            default: begin w_a = '0; w_b = '0; end
        endcase
    end

    // The most negative value negates onto itself, which is its correct unsigned magnitude.
    assign w_a_mag  = w_a[WIDTH-1] ? (~w_a + 1'b1) : w_a;
    assign w_b_mag  = w_b[WIDTH-1] ? (~w_b + 1'b1) : w_b;
    assign w_prod   = r_sign ? $signed(~r_acc + 1'b1) : $signed(r_acc);
    assign w_scaled = w_prod >>> FRAC;

`ifdef MUL_SAT_EN
    localparam logic signed [PW-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        if (w_scaled > MAX_V)
            w_fmt = {1'b0, {(WIDTH-1){1'b1}}};
        else if (w_scaled < MIN_V)
            w_fmt = {1'b1, {(WIDTH-1){1'b0}}};
        else
            w_fmt = w_scaled[WIDTH-1:0];
    end
`else
    logic w_unused_high;
    assign w_unused_high = ^w_scaled[PW-1:WIDTH];
    assign w_fmt         = w_scaled[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (unit_rst) begin
            // Result and sel_err survive so the adder can still consume the product.
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        if (sel != 2'd0) begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_sign   <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= RUN;
                        end else begin
                            r_sel_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        if (r_mplier[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1))
                            r_state <= FIN;
                    end
                end
                FIN: begin
                    r_result <= w_fmt;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result  = r_result;
    assign done    = r_done;
    assign busy    = r_busy;
    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_neuron_mul_unit.sv
// Randomised bench for neuron_mul_unit against an integer-arithmetic product model.
module tb_neuron_mul_unit;
    localparam int W = 16;
    localparam int F = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          unit_rst = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic [W-1:0]  x1 = '0, x2 = '0, x3 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic [W-1:0]  result;
    logic          done, busy, sel_err;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_result = '0;

    always #5 clk = ~clk;

    neuron_mul_unit #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .reset(reset), .unit_rst(unit_rst), .enable(enable), .sel(sel),
        .x1(x1), .x2(x2), .x3(x3), .w1(w1), .w2(w2), .w3(w3),
        .result(result), .done(done), .busy(busy), .sel_err(sel_err)
    );

    // Real-valued Q8.8 product, floor-scaled, then wrapped or clamped.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = p >>> F;
`ifdef MUL_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return W'(s);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive_operands(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        x1 = W'($urandom); x2 = W'($urandom); x3 = W'($urandom);
        w1 = W'($urandom); w2 = W'($urandom); w3 = W'($urandom);
        case (s)
            2'd1: begin x1 = a; w1 = b; end
            2'd2: begin x2 = a; w2 = b; end
            default: begin x3 = a; w3 = b; end
        endcase
        sel = s;
    endtask

    task automatic start_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive_operands(s, a, b);
        enable = 1'b1;
    endtask

    // lat counts edges after the sampling edge; -1 if done never rose within the budget.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic release_unit();
        @(negedge clk);
        unit_rst = 1'b1; enable = 1'b0; sel = 2'd0;
        @(negedge clk);
        unit_rst = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [W-1:0] exp;
        exp = model(a, b);
        start_op(s, a, b);
        wait_done(lat);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL %s_latency got %0d want 17", name, lat); end
        checks++;
        if (result !== exp) begin errors++; $display("FAIL %s_result got %h want %h", name, result, exp); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done got %b want 0", name, busy); end
        exp_result = exp;
        $display("op %s sel=%0d a=%h b=%h result=%h lat=%0d", name, s, a, b, result, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, done, busy, sel_err} !== {{W{1'b0}}, 3'b000}) begin
            errors++; $display("FAIL reset got r=%h d=%b b=%b e=%b want all 0", result, done, busy, sel_err);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_result = '0;
    endtask

    task automatic test_basic();
        run_and_check("basic", 2'd1, 16'h0200, 16'h0180);
        checks++;
        if (result !== 16'h0300) begin errors++; $display("FAIL basic_const got %h want 0300", result); end
    endtask

    task automatic test_handshake_release();
        @(negedge clk);
        unit_rst = 1'b1; enable = 1'b0; sel = 2'd0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL release_done got %b want 0", done); end
        checks++;
        if (result !== 16'h0300) begin errors++; $display("FAIL release_hold got %h want 0300", result); end
        @(negedge clk);
        unit_rst = 1'b0;
        run_and_check("after_release", 2'd2, 16'h0100, 16'h0100);
        release_unit();
    endtask

    task automatic test_negative();
        run_and_check("negative", 2'd3, 16'hFF00, 16'h0280);
        release_unit();
        run_and_check("min_times_min", 2'd3, 16'h8000, 16'h8000);
        $display("min_times_min observed result=%h", result);
        release_unit();
    endtask

    task automatic test_overflow();
        run_and_check("overflow", 2'd2, 16'h7F00, 16'h7F00);
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_operands(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
            enable = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || result !== exp_result) begin
                errors++; $display("FAIL done_hold cyc %0d got d=%b r=%h want d=1 r=%h", i, done, result, exp_result);
            end
        end
        release_unit();
    endtask

    task automatic test_abort(input bit use_unit_rst);
        bit saw_done;
        start_op(2'd1, pick_operand(), pick_operand());
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort%0d_busy_run got %b want 1", use_unit_rst, busy); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (use_unit_rst) unit_rst = 1'b1;
        else enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort%0d_busy got %b want 0", use_unit_rst, busy); end
        @(negedge clk);
        unit_rst = 1'b0; enable = 1'b0; sel = 2'd0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort%0d_idle got done/busy activity want none", use_unit_rst); end
        checks++;
        if (result !== exp_result) begin errors++; $display("FAIL abort%0d_result got %h want %h", use_unit_rst, result, exp_result); end
    endtask

    // Each new op is requested in the same cycle as unit_rst, which must win for one edge.
    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic [1:0]   s;
            logic [W-1:0] a, b, exp;
            int           lat;
            s = 2'($urandom_range(1, 3));
            a = pick_operand();
            b = pick_operand();
            exp = model(a, b);
            @(negedge clk);
            drive_operands(s, a, b);
            enable = 1'b1;
            unit_rst = (i > 0);
            if (i > 0) begin
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL b2b_unit_rst_wins %0d got d=%b b=%b want 0 0", i, done, busy);
                end
                @(negedge clk);
                unit_rst = 1'b0;
            end
            wait_done(lat);
            checks++;
            if (lat !== 17) begin errors++; $display("FAIL b2b_latency %0d got %0d want 17", i, lat); end
            checks++;
            if (result !== exp) begin errors++; $display("FAIL b2b_result %0d a=%h b=%h got %h want %h", i, a, b, result, exp); end
            exp_result = exp;
            $display("b2b %0d sel=%0d a=%h b=%h result=%h", i, s, a, b, result);
        end
        release_unit();
    endtask

    task automatic test_sel_err();
        bit started;
        @(negedge clk);
        sel = 2'd0; enable = 1'b1;
        started = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) started = 1'b1;
        end
        checks++;
        if (started) begin errors++; $display("FAIL sel_err_no_start got activity want none"); end
        checks++;
        if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_set got %b want 1", sel_err); end
        release_unit();
        #1;
        checks++;
        if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_sticky got %b want 1", sel_err); end
        checks++;
        if (result !== exp_result) begin errors++; $display("FAIL sel_err_result got %h want %h", result, exp_result); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sel_err !== 1'b0 || result !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL sel_err_reset got e=%b r=%h d=%b want 0 0000 0", sel_err, result, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_handshake_release();
        test_negative();
        test_overflow();
        test_done_hold();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_sel_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
